scrambler: RTL and testbench

SCRAMBLER -- requirements
Module: scrambler

---
 rtl/scrambler_pkg.sv | 64 ++++++
 rtl/descrambler.sv | 31 +++
 rtl/scrambler.sv | 64 ++++++
 tb/tb_scrambler.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/scrambler_pkg.sv
// Shared types and word-parallel helpers for the 64b/66b scrambler pair.
// G(x) = 1 + x^39 + x^58, bit 0 of each word is on the wire first.
package scrambler_pkg;

  localparam int SCR_W       = 64;
  localparam int SCR_STATE_W = 58;
  localparam int SCR_TAP_A   = 39;
  localparam int SCR_TAP_B   = 58;
  localparam int SCR_HIST_W  = SCR_W + SCR_STATE_W;

  typedef logic [SCR_STATE_W-1:0] scr_state_t;
  typedef logic [SCR_W-1:0]       scr_word_t;

  // Line history oldest-first: state bits, then this word's line bits.
  // Tap n for bit i then sits at index SCR_STATE_W + i - n.
  function automatic logic [SCR_HIST_W-1:0] scr_hist_init(
    input scr_state_t st
  );
    logic [SCR_HIST_W-1:0] h;
    h = '0;
    for (int j = 0; j < SCR_STATE_W; j++)
      h[j] = st[SCR_STATE_W-1-j];
    return h;
  endfunction

  function automatic scr_word_t scr_word(
    input scr_word_t  din,
    input scr_state_t st
  );
    logic [SCR_HIST_W-1:0] h;
    h = scr_hist_init(st);
    for (int i = 0; i < SCR_W; i++)
      h[SCR_STATE_W+i] = din[i]
        ^ h[SCR_STATE_W+i-SCR_TAP_A]
        ^ h[SCR_STATE_W+i-SCR_TAP_B];
    return h[SCR_HIST_W-1:SCR_STATE_W];
  endfunction

  function automatic scr_word_t dscr_word(
    input scr_word_t  din,
    input scr_state_t st
  );
    logic [SCR_HIST_W-1:0] h;
    scr_word_t             d;
    h = scr_hist_init(st);
    h[SCR_HIST_W-1:SCR_STATE_W] = din;
    for (int i = 0; i < SCR_W; i++)
      d[i] = din[i]
        ^ h[SCR_STATE_W+i-SCR_TAP_A]
        ^ h[SCR_STATE_W+i-SCR_TAP_B];
    return d;
  endfunction

  // Newest line bit lands in state bit 0.
  function automatic scr_state_t scr_next(
    input scr_word_t line
  );
    scr_state_t s;
    for (int k = 0; k < SCR_STATE_W; k++)
      s[k] = line[SCR_W-1-k];
    return s;
  endfunction

endpackage

// File: rtl/descrambler.sv
// Self-synchronous 64-bit descrambler, G(x) = 1 + x^39 + x^58.
// History tracks received line bits; output is combinational.
module descrambler
  import scrambler_pkg::*;
#(
  parameter logic [57:0] RESET = 58'h3FF_FFFF_FFFF_FFFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        descrambler_next,
  input  logic        descrambler_load,
  input  logic [57:0] descrambler_load_data,
  input  logic [63:0] descrambler_in,
  output logic [63:0] descrambler_out
);

  scr_state_t hist;

  assign descrambler_out = dscr_word(descrambler_in, hist);

  // History register: reset > load > next > hold.
  always_ff @(posedge clk) begin
    if (!reset)
      hist <= RESET;
    else if (descrambler_load)
      hist <= descrambler_load_data;
    else if (descrambler_next)
      hist <= scr_next(descrambler_in);
  end

endmodule

// File: rtl/scrambler.sv
// Self-synchronous 64-bit scrambler, G(x) = 1 + x^39 + x^58.
// Define SCRAMBLER_SELFCHECK_EN to add a descrambler loopback check.
module scrambler
  import scrambler_pkg::*;
#(
  parameter logic [57:0] RESET = 58'h3FF_FFFF_FFFF_FFFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        scrambler_next,
  input  logic        scrambler_load,
  input  logic [57:0] scrambler_load_data,
  input  logic [63:0] scrambler_in,
`ifdef SCRAMBLER_SELFCHECK_EN
  output logic [63:0] scrambler_out,
  output logic        scrambler_err
`else
  output logic [63:0] scrambler_out
`endif
);

  scr_state_t state;

  assign scrambler_out = scr_word(scrambler_in, state);

  // Scrambler state: reset > load > next > hold.
  always_ff @(posedge clk) begin
    if (!reset)
      state <= RESET;
    else if (scrambler_load)
      state <= scrambler_load_data;
    else if (scrambler_next)
      state <= scr_next(scrambler_out);
  end

`ifdef SCRAMBLER_SELFCHECK_EN
  logic [63:0] chk_in;
  logic [63:0] chk_out;

  assign chk_in = scrambler_out;

  descrambler #(
    .RESET(RESET)
  ) u_chk (
    .clk                  (clk),
    .reset                (reset),
    .descrambler_next     (scrambler_next),
    .descrambler_load     (scrambler_load),
    .descrambler_load_data(scrambler_load_data),
    .descrambler_in       (chk_in),
    .descrambler_out      (chk_out)
  );

  // Flag a word that does not survive the loopback.
  always_ff @(posedge clk) begin
    if (!reset)
      scrambler_err <= 1'b0;
    else
      scrambler_err <= scrambler_next
        && (chk_out != scrambler_in);
  end
`endif

endmodule

// File: tb/tb_scrambler.sv
// Testbench for scrambler: serial bit-level reference model,
// randomized words, standalone descrambler on the receive side.
module tb_scrambler;

  localparam logic [57:0] RST1 = 58'h2382_2123_2123;

  logic        clk = 1'b0;
  logic        reset;
  logic        nxt;
  logic        load;
  logic [57:0] ldata;
  logic [63:0] din;
  logic [63:0] out0;
  logic [63:0] out1;
  logic [63:0] rx_out;
`ifdef SCRAMBLER_SELFCHECK_EN
  logic        err0;
  logic        err1;
`endif

  int checks = 0;
  int errors = 0;

  logic [57:0] m0;
  logic [57:0] m1;

  always #5 clk = ~clk;

  scrambler #(.RESET(58'h0)) u0 (
    .clk                (clk),
    .reset              (reset),
    .scrambler_next     (nxt),
    .scrambler_load     (load),
    .scrambler_load_data(ldata),
    .scrambler_in       (din),
`ifdef SCRAMBLER_SELFCHECK_EN
    .scrambler_err      (err0),
`endif
    .scrambler_out      (out0)
  );

  scrambler #(.RESET(RST1)) u1 (
    .clk                (clk),
    .reset              (reset),
    .scrambler_next     (nxt),
    .scrambler_load     (load),
    .scrambler_load_data(ldata),
    .scrambler_in       (din),
`ifdef SCRAMBLER_SELFCHECK_EN
    .scrambler_err      (err1),
`endif
    .scrambler_out      (out1)
  );

  descrambler #(.RESET(RST1)) u_rx (
    .clk                  (clk),
    .reset                (reset),
    .descrambler_next     (nxt),
    .descrambler_load     (load),
    .descrambler_load_data(ldata),
    .descrambler_in       (out1),
    .descrambler_out      (rx_out)
  );

  // Serial model: h[j] is the line bit sent j+1 bits ago.
  function automatic logic [63:0] ref_word(
    input logic [63:0] w, input logic [57:0] h);
    logic [57:0] sh;
    logic [63:0] o;
    logic        b;
    sh = h;
    o  = '0;
    for (int i = 0; i < 64; i++) begin
      b    = w[i] ^ sh[38] ^ sh[57];
      o[i] = b;
      sh   = {sh[56:0], b};
    end
    return o;
  endfunction

  function automatic logic [57:0] ref_hist(
    input logic [63:0] w, input logic [57:0] h);
    logic [57:0] sh;
    logic        b;
    sh = h;
    for (int i = 0; i < 64; i++) begin
      b  = w[i] ^ sh[38] ^ sh[57];
      sh = {sh[56:0], b};
    end
    return sh;
  endfunction

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  task automatic drive(input logic r, input logic n,
    input logic l, input logic [57:0] ld, input logic [63:0] w);
    reset = r;
    nxt   = n;
    load  = l;
    ldata = ld;
    din   = w;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    if (!reset) begin
      m0 = '0;
      m1 = RST1;
    end else if (load) begin
      m0 = ldata;
      m1 = ldata;
    end else if (nxt) begin
      m0 = ref_hist(din, m0);
      m1 = ref_hist(din, m1);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [63:0] w;
    logic [63:0] e0;
    logic [63:0] e1;
    drive(1'b0, 1'b1, 1'b0, '0, rnd64());
    tick();
    for (int c = 0; c < 2; c++) begin
      w = rnd64();
      drive(1'b0, 1'b1, 1'b1, 58'h1234, w);
      e0 = ref_word(w, 58'h0);
      e1 = ref_word(w, RST1);
      checks++;
      if (out0 !== e0) begin
        errors++;
        $display("FAIL reset_out0 got %h exp %h", out0, e0);
      end
      checks++;
      if (out1 !== e1) begin
        errors++;
        $display("FAIL reset_out1 got %h exp %h", out1, e1);
      end
      checks++;
      if (rx_out !== w) begin
        errors++;
        $display("FAIL reset_rx got %h exp %h", rx_out, w);
      end
`ifdef SCRAMBLER_SELFCHECK_EN
      checks++;
      if (err1 !== 1'b0) begin
        errors++;
        $display("FAIL reset_err got %b exp 0", err1);
      end
`endif
      tick();
    end
  endtask

  task automatic test_zero();
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    tick();
    for (int c = 0; c < 4; c++) begin
      drive(1'b1, 1'b1, 1'b0, '0, 64'h0);
      checks++;
      if (out0 !== 64'h0) begin
        errors++;
        $display("FAIL zero_out0 cyc %0d got %h exp 0", c, out0);
      end
      tick();
    end
  endtask

  task automatic test_hold();
    logic [63:0] e1;
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    tick();
    for (int c = 0; c < 3; c++) begin
      drive(1'b1, 1'b0, 1'b0, '0, 64'h1);
      e1 = ref_word(64'h1, m1);
      checks++;
      if (out0 !== 64'h0400_0080_0000_0001) begin
        errors++;
        $display("FAIL hold_out0 cyc %0d got %h exp %h",
          c, out0, 64'h0400_0080_0000_0001);
      end
      checks++;
      if (out1 !== e1) begin
        errors++;
        $display("FAIL hold_out1 cyc %0d got %h exp %h", c, out1, e1);
      end
      tick();
    end
  endtask

  task automatic test_load_wins();
    for (int c = 0; c < 4; c++) begin
      drive(1'b1, 1'b1, 1'b0, '0, rnd64());
      tick();
    end
    drive(1'b1, 1'b1, 1'b1, 58'h0, rnd64());
    tick();
    drive(1'b1, 1'b1, 1'b0, '0, 64'h0);
    checks++;
    if (out0 !== 64'h0) begin
      errors++;
      $display("FAIL load_wins_out0 got %h exp 0", out0);
    end
    checks++;
    if (out1 !== 64'h0) begin
      errors++;
      $display("FAIL load_wins_out1 got %h exp 0", out1);
    end
    tick();
  endtask

  task automatic test_random(input int n, input bit mixed);
    logic [63:0] w;
    logic [63:0] e0;
    logic [63:0] e1;
    logic [63:0] l;
    logic        nx;
    logic        ld;
    int          bad;
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    tick();
    bad = 0;
    for (int c = 0; c < n; c++) begin
      w  = rnd64();
      l  = rnd64();
      nx = mixed ? 1'($urandom_range(0, 1)) : 1'b1;
      ld = mixed ? ($urandom_range(0, 15) == 0) : 1'b0;
      drive(1'b1, nx, ld, l[57:0], w);
      e0 = ref_word(w, m0);
      e1 = ref_word(w, m1);
      checks++;
      if (out0 !== e0 || out1 !== e1) begin
        errors++;
        if (bad++ < 5)
          $display("FAIL rand_out cyc %0d got %h/%h exp %h/%h",
            c, out0, out1, e0, e1);
      end
      checks++;
      if (rx_out !== w) begin
        errors++;
        if (bad++ < 5)
          $display("FAIL rand_rx cyc %0d got %h exp %h", c, rx_out, w);
      end
      tick();
`ifdef SCRAMBLER_SELFCHECK_EN
      checks++;
      if (err0 !== 1'b0 || err1 !== 1'b0) begin
        errors++;
        if (bad++ < 5)
          $display("FAIL rand_err cyc %0d got %b%b exp 00", c, err0, err1);
      end
`endif
    end
  endtask

  task automatic test_midstream_reset();
    logic [63:0] w;
    logic [63:0] e0;
    logic [63:0] e1;
    logic [63:0] l;
    for (int c = 0; c < 5; c++) begin
      drive(1'b1, 1'b1, 1'b0, '0, rnd64());
      tick();
    end
    l = rnd64();
    drive(1'b0, 1'b1, 1'b1, l[57:0], rnd64());
    tick();
    w  = rnd64();
    drive(1'b1, 1'b1, 1'b0, '0, w);
    e0 = ref_word(w, 58'h0);
    e1 = ref_word(w, RST1);
    checks++;
    if (out0 !== e0) begin
      errors++;
      $display("FAIL mid_reset_out0 got %h exp %h", out0, e0);
    end
    checks++;
    if (out1 !== e1) begin
      errors++;
      $display("FAIL mid_reset_out1 got %h exp %h", out1, e1);
    end
`ifdef SCRAMBLER_SELFCHECK_EN
    checks++;
    if (err1 !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_err got %b exp 0", err1);
    end
`endif
    tick();
  endtask

`ifdef SCRAMBLER_SELFCHECK_EN
  task automatic test_selfcheck();
    logic [63:0] f;
    drive(1'b1, 1'b1, 1'b0, '0, rnd64());
    f = out1 ^ 64'h1;
    force u1.chk_in = f;
    #1;
    tick();
    checks++;
    if (err1 !== 1'b1) begin
      errors++;
      $display("FAIL selfcheck_pulse got %b exp 1", err1);
    end
    release u1.chk_in;
    drive(1'b1, 1'b1, 1'b0, '0, rnd64());
    tick();
    checks++;
    if (err1 !== 1'b0) begin
      errors++;
      $display("FAIL selfcheck_clear got %b exp 0", err1);
    end
  endtask
`endif

  initial begin
    reset = 1'b0;
    nxt   = 1'b0;
    load  = 1'b0;
    ldata = '0;
    din   = '0;
    m0    = '0;
    m1    = RST1;
    @(negedge clk);
    test_reset();
    test_zero();
    test_hold();
    test_load_wins();
    test_random(1000, 1'b0);
    test_random(300, 1'b1);
    test_midstream_reset();
`ifdef SCRAMBLER_SELFCHECK_EN
    test_selfcheck();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
